// File: rtl/ahbl_splitter_n_if.sv
// AHB-Lite splitter bus bundle: fabric-side address/data-phase signals plus
// the per-slave fan-out/fan-in vectors.
//   slave  : view taken by the splitter (fabric inputs, slave responses in,
//            fabric response and per-slave selects out)
//   master : view taken by the fabric/peripheral model driving the splitter
interface ahbl_splitter_n_if #(
  parameter int NS = 5
);
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic [NS-1:0]     S_HSEL;
  logic [NS*32-1:0]  S_HRDATA;
  logic [NS-1:0]     S_HREADYOUT;
  logic [NS-1:0]     S_HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HREADY, S_HRDATA, S_HREADYOUT, S_HRESP,
    output HREADYOUT, HRESP, HRDATA, S_HSEL
  );

  modport master (
    output HSEL, HADDR, HTRANS, HREADY, S_HRDATA, S_HREADYOUT, S_HRESP,
    input  HREADYOUT, HRESP, HRDATA, S_HSEL
  );
endinterface

// File: rtl/ahbl_splitter_n.sv
// AHB-Lite 1-to-NS peripheral splitter.
//  - Combinational address decode on HADDR[DEC_LO+:DEC_W] to a one-hot S_HSEL
//    (lowest matching slot wins).
//  - Data-phase response mux driven by the registered select sel_d.
//  - Built-in default slave: unmapped accesses get a two-cycle ERROR.
//  - Watchdog: a slave stalling TIMEOUT_CYC cycles is abandoned with an ERROR
//    pair and a sticky TO_FLAG / TO_SLOT record (TIMEOUT_CYC=0 disables).
// Ports:
//  HCLK, HRESETn     clock, synchronous active-low reset
//  bus (slave)       fabric HSEL/HADDR/HTRANS/HREADY in, HREADYOUT/HRESP/HRDATA
//                    out; S_HSEL out, S_HRDATA/S_HREADYOUT/S_HRESP in
//  TO_FLAG, TO_SLOT  sticky timeout flag and slot index of last timeout
//  TO_CLR            one-cycle pulse clearing TO_FLAG
module ahbl_splitter_n #(
  parameter int                  NS            = 5,
  parameter int                  DEC_LO        = 24,
  parameter int                  DEC_W         = 4,
  parameter logic [NS*DEC_W-1:0] SLOT_IDS      = {4'h4, 4'h3, 4'h2, 4'h1, 4'h0},
  parameter logic [31:0]         DEFAULT_RDATA = 32'hBADDBEEF,
  parameter int                  TIMEOUT_CYC   = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahbl_splitter_n_if.slave      bus,
  output logic                  TO_FLAG,
  output logic [3:0]            TO_SLOT,
  input  logic                  TO_CLR
);

  typedef enum logic [1:0] {NORM, ERR1, ERR2} st_t;

  localparam logic [15:0] TO_LIM = (TIMEOUT_CYC == 0) ? 16'd0 : 16'(TIMEOUT_CYC - 1);

  st_t           st;
  logic [NS-1:0] sel_d;
  logic [15:0]   wcnt;
  logic [NS-1:0] s_hsel;
  logic          xfer, miss, timeout;
  logic          m_rdy, m_resp;
  logic [31:0]   m_data;
  logic [3:0]    m_idx;

  // Reverse scan so the lowest matching slot is the one left set.
  always_comb begin
    s_hsel = '0;
    for (int i = NS - 1; i >= 0; i--)
      if (bus.HSEL && bus.HADDR[DEC_LO+:DEC_W] == SLOT_IDS[i*DEC_W+:DEC_W]) begin
        s_hsel    = '0;
        s_hsel[i] = 1'b1;
      end
  end
  assign bus.S_HSEL = s_hsel;

  assign xfer = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign miss = xfer & (s_hsel == '0);

  // Data-phase mux; sel_d is one-hot or zero, zero selects the default slave.
  always_comb begin
    m_rdy  = 1'b1;
    m_resp = 1'b0;
    m_data = DEFAULT_RDATA;
    m_idx  = 4'd0;
    for (int i = NS - 1; i >= 0; i--)
      if (sel_d[i]) begin
        m_rdy  = bus.S_HREADYOUT[i];
        m_resp = bus.S_HRESP[i];
        m_data = bus.S_HRDATA[i*32+:32];
        m_idx  = 4'(i);
      end
  end

  // Fires on the last allowed stall cycle, so the slave sees exactly
  // TIMEOUT_CYC stalled cycles before the splitter takes over with ERR1.
  assign timeout = (TIMEOUT_CYC != 0) && st == NORM && sel_d != '0 && !m_rdy
                   && wcnt == TO_LIM;

  always_comb begin
    bus.HREADYOUT = m_rdy;
    bus.HRESP     = m_resp;
    bus.HRDATA    = m_data;
    case (st)
      ERR1:    begin bus.HREADYOUT = 1'b0; bus.HRESP = 1'b1; bus.HRDATA = DEFAULT_RDATA; end
      ERR2:    begin bus.HREADYOUT = 1'b1; bus.HRESP = 1'b1; bus.HRDATA = DEFAULT_RDATA; end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      st      <= NORM;
      sel_d   <= '0;
      wcnt    <= '0;
      TO_FLAG <= 1'b0;
      TO_SLOT <= '0;
    end else if (timeout) begin
      st      <= ERR1;
      sel_d   <= '0;
      wcnt    <= '0;
      TO_FLAG <= 1'b1;
      TO_SLOT <= m_idx;
    end else begin
      if (TO_CLR) TO_FLAG <= 1'b0;
      if (bus.HREADY) sel_d <= xfer ? s_hsel : '0;
      if (sel_d == '0 || st != NORM || m_rdy) wcnt <= '0;
      else                                    wcnt <= wcnt + 16'd1;
      case (st)
        NORM:    if (miss) st <= ERR1;
        ERR1:    st <= ERR2;
        ERR2:    st <= miss ? ERR1 : NORM;
        default: st <= NORM;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{bus.HTRANS[0], bus.HADDR};

endmodule

// File: tb/tb_ahbl_splitter_n.sv
module tb_ahbl_splitter_n;
  localparam int NS = 5;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       TO_FLAG;
  logic [3:0] TO_SLOT;
  logic       TO_CLR;
  int         nchk = 0;
  int         nerr = 0;
  int         n;

  ahbl_splitter_n_if #(.NS(NS)) bus ();

  // Single-master fabric: bus-level HREADY is the splitter's own HREADYOUT.
  assign bus.HREADY = bus.HREADYOUT;

  ahbl_splitter_n #(.NS(NS), .TIMEOUT_CYC(8)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave),
    .TO_FLAG (TO_FLAG),
    .TO_SLOT (TO_SLOT),
    .TO_CLR  (TO_CLR)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic acc(input logic [31:0] a);
    bus.HSEL = 1'b1; bus.HADDR = a; bus.HTRANS = 2'b10;
  endtask

  task automatic idle();
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00;
  endtask

  task automatic rsp(input string tag, input logic rdy, input logic resp);
    chk({tag, ".rdy"}, {31'd0, bus.HREADYOUT}, {31'd0, rdy});
    chk({tag, ".resp"}, {31'd0, bus.HRESP}, {31'd0, resp});
  endtask

  initial begin
    HRESETn = 1'b0; TO_CLR = 1'b0;
    idle();
    bus.S_HREADYOUT = '1;
    bus.S_HRESP     = '0;
    for (int i = 0; i < NS; i++) bus.S_HRDATA[i*32+:32] = 32'hA000_0000 + 32'(i);
    bus.S_HRDATA[2*32+:32] = 32'h1234_5678;
    step(); step();
    HRESETn = 1'b1;
    #1;
    rsp("reset", 1'b1, 1'b0);
    chk("reset.rdata", bus.HRDATA, 32'hBADDBEEF);
    chk("reset.toflag", {31'd0, TO_FLAG}, 32'd0);

    // 1: read slot 2
    acc(32'h0200_0010); #1;
    chk("t1.shsel", {27'd0, bus.S_HSEL}, 32'b00100);
    step(); idle(); #1;
    rsp("t1.data", 1'b1, 1'b0);
    chk("t1.rdata", bus.HRDATA, 32'h1234_5678);
    step();
    chk("t1.idle_rdata", bus.HRDATA, 32'hBADDBEEF);

    // 2: unmapped access -> ERROR pair
    acc(32'h0900_0000); #1;
    chk("t2.shsel", {27'd0, bus.S_HSEL}, 32'd0);
    step(); idle(); #1;
    rsp("t2.err1", 1'b0, 1'b1);
    step(); rsp("t2.err2", 1'b1, 1'b1);
    step(); rsp("t2.norm", 1'b1, 1'b0);
    chk("t2.rdata", bus.HRDATA, 32'hBADDBEEF);

    // 3: slot 3 stalls three cycles, below the watchdog limit
    bus.S_HREADYOUT[3] = 1'b0;
    acc(32'h0300_0000);
    step(); idle(); #1;
    for (int k = 0; k < 3; k++) begin
      rsp($sformatf("t3.stall%0d", k), 1'b0, 1'b0);
      step();
    end
    bus.S_HREADYOUT[3] = 1'b1; #1;
    rsp("t3.done", 1'b1, 1'b0);
    chk("t3.rdata", bus.HRDATA, 32'hA000_0003);
    step();
    chk("t3.toflag", {31'd0, TO_FLAG}, 32'd0);

    // 4: slot 1 stuck -> 8 stall cycles, ERROR pair, sticky flag
    bus.S_HREADYOUT[1] = 1'b0;
    acc(32'h0100_0000);
    step(); idle(); #1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 1'b0) break;
      n++;
      step();
    end
    chk("t4.stalls", n, 32'd8);
    rsp("t4.err1", 1'b0, 1'b1);
    chk("t4.toflag", {31'd0, TO_FLAG}, 32'd1);
    chk("t4.toslot", {28'd0, TO_SLOT}, 32'd1);
    step(); rsp("t4.err2", 1'b1, 1'b1);
    step(); rsp("t4.norm", 1'b1, 1'b0);
    chk("t4.sticky", {31'd0, TO_FLAG}, 32'd1);
    bus.S_HREADYOUT[1] = 1'b1;
    TO_CLR = 1'b1;
    step(); TO_CLR = 1'b0; #1;
    chk("t4.clr", {31'd0, TO_FLAG}, 32'd0);

    // 5: second miss accepted in ERR2 -> no OKAY gap
    acc(32'h0900_0000);
    step(); idle(); #1;
    rsp("t5.err1a", 1'b0, 1'b1);
    step(); acc(32'h0F00_0000); #1;
    rsp("t5.err2a", 1'b1, 1'b1);
    step(); idle(); #1;
    rsp("t5.err1b", 1'b0, 1'b1);
    step(); rsp("t5.err2b", 1'b1, 1'b1);
    step(); rsp("t5.norm", 1'b1, 1'b0);

    // 6a: reset during ERR1
    acc(32'h0900_0000);
    step(); idle(); #1;
    rsp("t6a.err1", 1'b0, 1'b1);
    HRESETn = 1'b0;
    step(); HRESETn = 1'b1; #1;
    rsp("t6a.after", 1'b1, 1'b0);

    // 6b: time out slot 0 to set the flag, then reset inside a slot-0 wait state
    bus.S_HREADYOUT[0] = 1'b0;
    acc(32'h0000_0000);
    step(); idle();
    repeat (10) step();
    chk("t6b.toflag", {31'd0, TO_FLAG}, 32'd1);
    chk("t6b.toslot", {28'd0, TO_SLOT}, 32'd0);
    rsp("t6b.norm", 1'b1, 1'b0);
    acc(32'h0000_0000);
    step(); idle(); #1;
    rsp("t6b.wait", 1'b0, 1'b0);
    HRESETn = 1'b0;
    step(); HRESETn = 1'b1; #1;
    rsp("t6b.after", 1'b1, 1'b0);
    chk("t6b.flagclr", {31'd0, TO_FLAG}, 32'd0);
    bus.S_HREADYOUT[0] = 1'b1;
    step();
    rsp("t6b.idle", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
